// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage program counter.
// Defaults for address width and boot address live here so every user agrees.
package pc_pkg;
   localparam int          ADDR_WIDTH = 32;
   localparam logic [31:0] BOOT_ADDR  = 32'd0;
endpackage

// File: rtl/pc.sv
// Program counter: a WIDTH-bit register with load enable and synchronous reset.
// out is driven straight from the register; a deasserted write_enable stalls fetch.
module pc
   import pc_pkg::*;
#(
   parameter int               WIDTH       = ADDR_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(BOOT_ADDR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             write_enable,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] pc_reg;

   // Reset wins over a simultaneous load.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg <= RESET_VALUE;
      end else if (write_enable) begin
         pc_reg <= in;
      end
   end

   assign out = pc_reg;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for the program counter: vector table through a
// scoreboard queue, plus hand sequences for between-edge behaviour.
module tb_pc;
   import pc_pkg::*;

   logic        clk;
   logic        rst;
   logic        write_enable;
   logic [31:0] in;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        we;
      logic [31:0] din;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t        vecs[16];
   logic [31:0] exp_q[$];
   string       name_q[$];

   pc dut (
      .clk          (clk),
      .rst          (rst),
      .write_enable (write_enable),
      .in           (in),
      .out          (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: out=%h required=%h", nm, act, req);
      end else begin
         $display("ok   %s: out=%h", nm, act);
      end
   endtask

   initial begin
      logic [31:0] e;
      string       n;

      vecs[0]  = '{1'b1, 1'b0, 32'd1234,       32'd0,          "reset_no_we_1"};
      vecs[1]  = '{1'b1, 1'b0, 32'd1234,       32'd0,          "reset_no_we_2"};
      vecs[2]  = '{1'b1, 1'b1, 32'd1234,       32'd0,          "reset_we_prio_1"};
      vecs[3]  = '{1'b1, 1'b1, 32'd1234,       32'd0,          "reset_we_prio_2"};
      vecs[4]  = '{1'b0, 1'b0, 32'd1234,       32'd0,          "first_edge_stall"};
      vecs[5]  = '{1'b0, 1'b1, 32'd1234,       32'd1234,       "write_after_reset"};
      vecs[6]  = '{1'b0, 1'b1, 32'd99999999,   32'd99999999,   "b2b_write_1"};
      vecs[7]  = '{1'b0, 1'b1, 32'd12349876,   32'd12349876,   "b2b_write_2"};
      vecs[8]  = '{1'b0, 1'b0, 32'd5555,       32'd12349876,   "stall_1"};
      vecs[9]  = '{1'b0, 1'b0, 32'd5555,       32'd12349876,   "stall_2"};
      vecs[10] = '{1'b0, 1'b0, 32'd5555,       32'd12349876,   "stall_3"};
      vecs[11] = '{1'b0, 1'b1, 32'd5555,       32'd5555,       "stall_release"};
      vecs[12] = '{1'b0, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  "full_range"};
      vecs[13] = '{1'b1, 1'b1, 32'h0000_ABCD,  32'd0,          "mid_op_reset"};
      vecs[14] = '{1'b0, 1'b1, 32'h0000_1000,  32'h0000_1000,  "reset_release_load"};
      vecs[15] = '{1'b0, 1'b1, 32'h8000_0001,  32'h8000_0001,  "msb_lsb_pattern"};

      // Table: drive each vector, queue its expectation, compare after the edge.
      for (int i = 0; i < 16; i++) begin
         rst          = vecs[i].rst;
         write_enable = vecs[i].we;
         in           = vecs[i].din;
         exp_q.push_back(vecs[i].exp);
         name_q.push_back(vecs[i].name);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check(n, out, e);
      end

      // Load must not be visible before the capturing edge.
      rst          = 1'b0;
      write_enable = 1'b1;
      in           = 32'd1234;
      #3;
      check("pre_edge_hold", out, 32'h8000_0001);
      @(posedge clk);
      #1;
      check("post_edge_load", out, 32'd1234);

      // Reset raised between edges must wait for the next edge.
      #2;
      rst          = 1'b1;
      write_enable = 1'b0;
      #2;
      check("rst_between_edges", out, 32'd1234);
      @(posedge clk);
      #1;
      check("rst_at_edge", out, 32'd0);

      // First edge after release with enable low keeps the boot address.
      rst          = 1'b0;
      write_enable = 1'b0;
      in           = 32'h0000_7777;
      @(posedge clk);
      #1;
      check("release_no_we", out, 32'd0);
      write_enable = 1'b1;
      @(posedge clk);
      #1;
      check("release_then_we", out, 32'h0000_7777);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
